// File: rtl/sram_responder.sv
// sram_responder
// Target end of the shared SRAM bus. It takes the muxed request coming out of
// the SRAM control mux and serves it from an internal byte array. Access
// latency is set by WAIT_CYCLES wait states. Each accepted request gives back
// read data, a one-cycle done pulse and an error flag to whichever engine
// currently owns the bus.
//
// Optional feature: define SRAM_CLEAR_EN to zero the whole array after every
// reset. The sweep runs in a CLEAR state before the first request is accepted.
// Without the macro, leaving reset goes straight to IDLE and the array is left
// uninitialised.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sram_read  read request level
//   sram_write write request level
//   sram_addr  16-bit byte address
//   sram_data  8-bit write data
//   data_read  read data, valid in the done cycle and held until the next read
//   sram_busy  high while an access is in progress (WAIT, RESP, CLEAR)
//   sram_done  one-cycle completion pulse
//   sram_err   high in the done cycle for an out-of-range or illegal request
module sram_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [7:0]  ERR_DATA    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_read,
  input  logic        sram_write,
  input  logic [15:0] sram_addr,
  input  logic [7:0]  sram_data,
  output logic [7:0]  data_read,
  output logic        sram_busy,
  output logic        sram_done,
  output logic        sram_err
);

  localparam int         DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  // The wait counter is only 4 bits wide, so anything above 15 cannot be honoured.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_responder: WAIT_CYCLES must be in 0..15");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 16) begin : g_bad_addr
    $error("sram_responder: ADDR_BITS must be in 1..16");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_RELEASE
`ifdef SRAM_CLEAR_EN
    , ST_CLEAR
`endif
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_ILLEGAL
  } op_t;

`ifdef SRAM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  op_t           op_q, op_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
`ifdef SRAM_CLEAR_EN
  logic [ADDR_BITS-1:0] clr_q, clr_d;
`endif

  logic [7:0]           mem_q [DEPTH];
  logic [ADDR_BITS-1:0] memIdx;
  logic                 inRange;
  logic                 commit;
  logic                 memWe;

  // Only the latched address is ever used for the access. Any address bit at
  // or above ADDR_BITS makes the access out of range. The shift form still
  // works when ADDR_BITS is 16.
  assign memIdx  = addr_q[ADDR_BITS-1:0];
  assign inRange = ((addr_q >> ADDR_BITS) == 16'd0);
  assign commit  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign memWe   = commit && (op_q == OP_WRITE) && inRange;

  // Control and datapath registers. Reset wins over everything, including a
  // commit on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wdata_q <= 8'h00;
      op_q    <= OP_READ;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
`ifdef SRAM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef SRAM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // The byte array has no reset, so contents survive rst. Writes are masked
  // while rst is high. That way a reset on the commit edge drops the write,
  // and a reset during CLEAR does not keep sweeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (memWe) begin
        mem_q[memIdx] <= wdata_q;
      end
`ifdef SRAM_CLEAR_EN
      else if (state_q == ST_CLEAR) begin
        mem_q[clr_q] <= 8'h00;
      end
`endif
    end
  end

  // Next-state logic. Request inputs are looked at only in IDLE (to accept a
  // request) and in RELEASE (to wait for the level to drop). A request level
  // that stays high therefore produces exactly one access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef SRAM_CLEAR_EN
    clr_d   = clr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sram_read || sram_write) begin
          addr_d  = sram_addr;
          wdata_d = sram_data;
          cnt_d   = WAIT_LOAD;
          err_d   = 1'b0;
          state_d = ST_WAIT;
          if (sram_read && sram_write) begin
            op_d = OP_ILLEGAL;
          end else if (sram_write) begin
            op_d = OP_WRITE;
          end else begin
            op_d = OP_READ;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          case (op_q)
            OP_READ: begin
              err_d   = !inRange;
              rdata_d = inRange ? mem_q[memIdx] : ERR_DATA;
            end
            OP_WRITE: begin
              err_d = !inRange;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      ST_RESP: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (!sram_read && !sram_write) begin
          state_d = ST_IDLE;
        end
      end

`ifdef SRAM_CLEAR_EN
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == ADDR_BITS'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // sram_err is qualified by the RESP state so it is high only in the done cycle.
  always_comb begin
    sram_busy = (state_q == ST_WAIT) || (state_q == ST_RESP)
`ifdef SRAM_CLEAR_EN
                || (state_q == ST_CLEAR)
`endif
                ;
    sram_done = (state_q == ST_RESP);
    sram_err  = (state_q == ST_RESP) && err_q;
    data_read = rdata_q;
  end

endmodule
